// File: rtl/mac_result_reader.sv
// Circular result buffer with frame tagging: push-to-valid latency 1 cycle.
// Backpressure: ready_i low holds the head word, hold_o warns at D-1, and results arriving while full with no pop are dropped and flagged sticky.
module mac_result_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 2,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  result_vld_i,
    input  logic                  flush_i,
    input  logic                  clr_ovf_i,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  valid_o,
    output logic                  hold_o,
    output logic [ADDR_LINES:0]   count_o,
    output logic                  overflow_o
);

    localparam int D  = 1 << ADDR_LINES;
    localparam int CW = ADDR_LINES + 1;
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    localparam logic [CW-1:0] DEPTH      = CW'(D);
    localparam logic [CW-1:0] HOLD_LEVEL = CW'(D - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

    logic [DATA_WIDTH:0]   mem_q [D];
    logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  ovf_q, ovf_d;

    logic pop;
    logic push;
    logic drop;
    logic wr_en;

    always_comb begin
        pop   = (count_q != '0) && ready_i;
        push  = result_vld_i && ((count_q < DEPTH) || pop);
        drop  = result_vld_i && (count_q == DEPTH) && !pop;
        wr_en = push && !flush_i;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        frame_d  = frame_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            frame_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                frame_d  = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // A coincident drop outranks the clear so no loss goes unreported.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            frame_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {(frame_q == FRAME_LAST), result_i};
        end
    end

    // Storage is unreset, so last is gated to keep it clean while empty.
    assign valid_o    = (count_q != '0);
    assign data_o     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign last_o     = valid_o && mem_q[rd_ptr_q][DATA_WIDTH];
    assign hold_o     = (count_q >= HOLD_LEVEL);
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mac_result_reader.sv
// Directed and randomized checks of mac_result_reader against a queue-based reference model.
module tb_mac_result_reader;

    localparam int DW = 32;
    localparam int AL = 2;
    localparam int FL = 8;
    localparam int D  = 1 << AL;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic [DW-1:0] result_i;
    logic          result_vld_i;
    logic          flush_i;
    logic          clr_ovf_i;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic          last_o;
    logic          valid_o;
    logic          hold_o;
    logic [AL:0]   count_o;
    logic          overflow_o;

    mac_result_reader #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .FRAME_LEN(FL)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .result_i(result_i), .result_vld_i(result_vld_i),
        .flush_i(flush_i), .clr_ovf_i(clr_ovf_i), .ready_i(ready_i), .data_o(data_o),
        .last_o(last_o), .valid_o(valid_o), .hold_o(hold_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          last;
        logic [DW-1:0] d;
    } entry_t;

    entry_t q[$];
    int     fc;
    logic   m_ovf;
    int     total = 0;
    int     bad   = 0;
    int     lasts_seen;
    int     words_seen;
    int     last_pos[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("valid", 64'(valid_o), 64'(n != 0));
        check("count", 64'(count_o), 64'(n));
        check("hold", 64'(hold_o), 64'(n >= D - 1));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        if (n != 0) begin
            check("data", 64'(data_o), 64'(q[0].d));
            check("last", 64'(last_o), 64'(q[0].last));
        end
    endtask

    task automatic model_reset();
        q.delete();
        fc    = 0;
        m_ovf = 1'b0;
    endtask

    // Applies the buffer rules to the pre-edge model state.
    task automatic model_edge(input logic v, input logic [DW-1:0] d, input logic r,
                              input logic f, input logic c);
        logic   pop, full;
        entry_t e;
        pop  = (q.size() != 0) && r;
        full = (q.size() == D);
        if (v && full && !pop) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (f) begin
            q.delete();
            fc = 0;
        end else begin
            if (pop) begin
                words_seen++;
                if (q[0].last) begin
                    lasts_seen++;
                    last_pos.push_back(words_seen);
                end
                void'(q.pop_front());
            end
            if (v && (!full || pop)) begin
                e.last = (fc == FL - 1);
                e.d    = d;
                q.push_back(e);
                fc = (fc + 1) % FL;
            end
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic c);
        @(negedge clk_i);
        result_vld_i = v;
        result_i     = d;
        ready_i      = r;
        flush_i      = f;
        clr_ovf_i    = c;
        @(posedge clk_i);
        model_edge(v, d, r, f, c);
        #1;
        check_all();
    endtask

    initial begin
        rstn_i = 1'b0; result_i = '0; result_vld_i = 1'b0;
        flush_i = 1'b0; clr_ovf_i = 1'b0; ready_i = 1'b0;
        model_reset();
        lasts_seen = 0; words_seen = 0;
        #12;
        check_all();
        check("rst_last", 64'(last_o), 64'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Single word, one-cycle latency, then popped.
        step(1'b1, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
        check("single_data", 64'(data_o), 64'h0000_00A5);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("single_empty", 64'(count_o), 64'(0));

        // Fill with no ready, drop the fifth, drain in order.
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
        check("fill_ovf", 64'(overflow_o), 64'(1));
        check("fill_count", 64'(count_o), 64'(4));
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 64'(data_o), 64'(i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 64'(overflow_o), 64'(0));

        // Full buffer with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
        check("full_pp_count", 64'(count_o), 64'(4));
        check("full_pp_ovf", 64'(overflow_o), 64'(0));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Sixteen words streamed; last must land on words 8 and 16.
        lasts_seen = 0; words_seen = 0; last_pos.delete();
        for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("frame_lasts", 64'(lasts_seen), 64'(2));
        if (last_pos.size() == 2) begin
            check("frame_pos0", 64'(last_pos[0]), 64'(8));
            check("frame_pos1", 64'(last_pos[1]), 64'(16));
        end

        // Flush with a push pending restarts the frame.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        check("flush_count", 64'(count_o), 64'(0));
        check("flush_valid", 64'(valid_o), 64'(0));
        lasts_seen = 0; words_seen = 0; last_pos.delete();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_frame", 64'(lasts_seen), 64'(1));
        if (last_pos.size() == 1) check("flush_pos", 64'(last_pos[0]), 64'(8));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-stream with two entries and overflow set.
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count_o), 64'(2));
        check("pre_rst_ovf", 64'(overflow_o), 64'(1));
        #2;
        rstn_i = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_valid", 64'(valid_o), 64'(0));
        check("arst_last", 64'(last_o), 64'(0));
        check("arst_hold", 64'(hold_o), 64'(0));
        @(negedge clk_i);
        rstn_i = 1'b1;
        lasts_seen = 0; words_seen = 0; last_pos.delete();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("rst_frame", 64'(lasts_seen), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_result_reader.md
MAC_RESULT_READER -- requirements
Module: mac_result_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the result word width.
REQ-002 SHALL have parameter ADDR_LINES, default 2, the buffer address width; buffer depth D = 2^ADDR_LINES.
REQ-003 SHALL have parameter FRAME_LEN, default 8, the number of results per frame (must be >= 1).
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port result_i, input, DATA_WIDTH bits: MAC result word.
REQ-007 SHALL have port result_vld_i, input, 1 bit: result_i is final this cycle (push request).
REQ-008 SHALL have port flush_i, input, 1 bit: synchronous clear of buffer and frame counter.
REQ-009 SHALL have port clr_ovf_i, input, 1 bit: synchronous clear of overflow_o.
REQ-010 SHALL have port ready_i, input, 1 bit: downstream accepts data_o.
REQ-011 SHALL have port data_o, output, DATA_WIDTH bits: head-of-buffer word.
REQ-012 SHALL have port last_o, output, 1 bit: data_o is the final word of a frame.
REQ-013 SHALL have port valid_o, output, 1 bit: data_o/last_o are valid.
REQ-014 SHALL have port hold_o, output, 1 bit: stall request to the MAC controller.
REQ-015 SHALL have port count_o, output, ADDR_LINES+1 bits: current occupancy, 0..D.
REQ-016 SHALL have port overflow_o, output, 1 bit: sticky flag, a result was dropped.

Function
REQ-017 SHALL store D entries of {last bit, DATA_WIDTH data} in a circular buffer with rd_ptr/wr_ptr of ADDR_LINES bits that wrap from D-1 to 0.
REQ-018 SHALL define pop = valid_o && ready_i; push = result_vld_i && (count_o < D || pop).
REQ-019 SHALL write result_i at wr_ptr on push and increment wr_ptr; on pop it SHALL increment rd_ptr.
REQ-020 SHALL update count_o: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 SHALL drive valid_o = (count_o != 0), data_o/last_o = entry at rd_ptr, combinationally from registers.
REQ-022 SHALL have one-cycle latency: push at edge t into an empty buffer gives valid_o high after edge t.
REQ-023 SHALL hold data_o and last_o stable while valid_o && !ready_i.
REQ-024 SHALL drive hold_o = (count_o >= D-1) combinationally from count_o.
REQ-025 SHALL drop result_vld_i when count_o == D and pop is low, leave the buffer unchanged, and set overflow_o on the next edge.
REQ-026 SHALL keep overflow_o set until clr_ovf_i or reset; if clr_ovf_i and a drop coincide, overflow_o SHALL remain set.
REQ-027 SHALL keep a frame counter 0..FRAME_LEN-1, incremented on each push and wrapping to 0; the stored last bit SHALL be 1 when the counter equals FRAME_LEN-1 at push.
REQ-028 SHALL treat dropped results as not counted by the frame counter.
REQ-029 SHALL, on flush_i, zero both pointers, count_o and the frame counter, and SHALL ignore push and pop in that cycle; overflow_o SHALL be unaffected.

Reset
REQ-030 SHALL, while rstn_i is low, asynchronously force rd_ptr, wr_ptr, count_o, frame counter and overflow_o to 0; thus valid_o=0, hold_o=0 (for D>1), last_o=0.
REQ-031 SHALL leave buffer data contents unreset; data_o is don't-care while valid_o=0.
REQ-032 SHALL discard in-flight entries on reset mid-operation and restart the frame count at 0.

Verification
REQ-033 Single push 0x0000_00A5 into empty buffer, ready_i=1 -> valid_o=1, data_o=0x0000_00A5 the cycle after; count_o returns to 0 after the pop.
REQ-034 D=4, ready_i=0, push 5 words -> hold_o=1 at count_o=3, count_o=4, 5th word dropped, overflow_o=1; then drain yields words 1..4 in order.
REQ-035 Full buffer, result_vld_i and ready_i high together -> push accepted, count_o stays 4, overflow_o stays 0.
REQ-036 FRAME_LEN=8, 16 pushes with continuous ready_i -> last_o=1 exactly on the 8th and 16th words.
REQ-037 3 entries held, assert flush_i with result_vld_i=1 -> next cycle count_o=0, valid_o=0; next push gets last_o only after 8 more words.
REQ-038 Deassert rstn_i mid-stream with count_o=2, overflow_o=1 -> all outputs 0 immediately, without a clock edge.
